// File: rtl/lsu_mem_if_pkg.sv
// Shared definitions for the memory-stage load/store unit.
// Width/sign codes match the decode-side DextControl encoding.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (used by lsu_mem_if).
package lsu_mem_if_pkg;

    localparam logic [2:0] DEXT_B  = 3'b000;
    localparam logic [2:0] DEXT_H  = 3'b001;
    localparam logic [2:0] DEXT_W  = 3'b010;
    localparam logic [2:0] DEXT_BU = 3'b100;
    localparam logic [2:0] DEXT_HU = 3'b101;

    // Legacy-compatible state encoding
    typedef logic [1:0] lsu_state_t;
    localparam lsu_state_t IDLE   = 2'd0;
    localparam lsu_state_t REQ    = 2'd1;
    localparam lsu_state_t WAIT_R = 2'd2;
    localparam lsu_state_t DONE   = 2'd3;

    // True when the access cannot be issued as-is: misaligned half/word or an illegal code
    function automatic logic dext_misaligned(input logic [2:0] dext, input logic [1:0] off);
        case (dext)
            DEXT_B, DEXT_BU: return 1'b0;
            DEXT_H, DEXT_HU: return off[0];
            DEXT_W:          return (off != 2'b00);
            default:         return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_if_if.sv
// Data-memory bus between the LSU (master) and the memory (slave).
interface lsu_mem_if_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [3:0]        dmem_be;
    logic [31:0]       dmem_wdata;
    logic              dmem_gnt;
    logic              dmem_rvalid;
    logic [31:0]       dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/lsu_mem_if_dext_align.sv
// Combinational lane steering: store byte enables / replicated data,
// and load byte/half extraction with sign or zero extension.
// Illegal codes fall through to word behaviour.
module lsu_mem_if_dext_align
    import lsu_mem_if_pkg::*;
(
    input  logic [2:0]  i_dext,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Store path: half uses off[1] only, so a misaligned half lands on its aligned lanes
    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        case (i_dext)
            DEXT_B, DEXT_BU: begin
                o_be    = 4'b0001 << i_off;
                o_wdata = {4{i_wdata[7:0]}};
            end
            DEXT_H, DEXT_HU: begin
                o_be    = i_off[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
            end
        endcase
    end

    // Load path: pick the addressed lane and extend to 32 bits
    always_comb begin
        w_byte  = i_rdata[{i_off, 3'b000} +: 8];
        w_half  = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
        o_rdata = i_rdata;
        case (i_dext)
            DEXT_B:  o_rdata = {{24{w_byte[7]}}, w_byte};
            DEXT_BU: o_rdata = {24'h000000, w_byte};
            DEXT_H:  o_rdata = {{16{w_half[15]}}, w_half};
            DEXT_HU: o_rdata = {16'h0000, w_half};
            default: o_rdata = i_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_if.sv
// Memory-stage load/store unit: issues one data-memory transaction per
// M-stage load/store, stalls the pipeline until it completes, and returns
// the extended load result in ReadDataM.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned/illegal accesses
// are suppressed and flagged on MisalignM instead of being issued aligned).
module lsu_mem_if
    import lsu_mem_if_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [2:0]        DextControlM,
    input  logic [ADDR_W-1:0] ALUResultM,
    input  logic [31:0]       WriteDataM,
    output logic [31:0]       ReadDataM,
    output logic              StallM,
    output logic              MisalignM,
    lsu_mem_if_if.master      dmem
);
    lsu_state_t  r_state;
    lsu_state_t  w_next;
    logic [1:0]  r_off;
    logic [31:0] r_rdata;
    logic        r_misalign;

    logic        w_op;
    logic        w_store;
    logic        w_trap;
    logic        w_req;
    logic [1:0]  w_off;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load_ext;

    assign w_op    = MemReadM | MemWriteM;
    assign w_store = MemWriteM;

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_trap = (r_state == IDLE) & w_op & dext_misaligned(DextControlM, ALUResultM[1:0]);
`else
    assign w_trap = 1'b0;
`endif

    // In IDLE the offset is not yet registered, so steer from the live address
    assign w_off = (r_state == IDLE) ? ALUResultM[1:0] : r_off;

    lsu_mem_if_dext_align u_align (
        .i_dext  (DextControlM),
        .i_off   (w_off),
        .i_wdata (WriteDataM),
        .i_rdata (dmem.dmem_rdata),
        .o_be    (w_be),
        .o_wdata (w_wdata),
        .o_rdata (w_load_ext)
    );

    // Next-state logic; gnt only matters in IDLE/REQ, rvalid only in WAIT_R
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_op) begin
                    if (w_trap)
                        w_next = DONE;
                    else if (dmem.dmem_gnt)
                        w_next = w_store ? DONE : WAIT_R;
                    else
                        w_next = REQ;
                end
            end
            REQ: begin
                if (dmem.dmem_gnt)
                    w_next = w_store ? DONE : WAIT_R;
            end
            WAIT_R: begin
                if (dmem.dmem_rvalid)
                    w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Bus request and pipeline stall outputs
    always_comb begin
        w_req           = ((r_state == IDLE) & w_op & ~w_trap) | (r_state == REQ);
        StallM          = ((r_state == IDLE) & w_op) | (r_state == REQ) | (r_state == WAIT_R);
        dmem.dmem_req   = w_req;
        dmem.dmem_we    = w_req & w_store;
        dmem.dmem_addr  = {ALUResultM[ADDR_W-1:2], 2'b00};
        dmem.dmem_be    = w_store ? w_be : 4'b1111;
        dmem.dmem_wdata = w_wdata;
    end

    // State, offset, load result and one-cycle misalign flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_off      <= 2'b00;
            r_rdata    <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_misalign <= 1'b0;
            if ((r_state == IDLE) && w_op)
                r_off <= ALUResultM[1:0];
            if (w_trap) begin
                r_misalign <= 1'b1;
                if (!w_store)
                    r_rdata <= '0;
            end
            if ((r_state == WAIT_R) && dmem.dmem_rvalid)
                r_rdata <= w_load_ext;
        end
    end

    assign ReadDataM = r_rdata;
    assign MisalignM = r_misalign;

endmodule
